// File: rtl/shader_pkg.sv
// Shared definitions for the PWM row shader.
//   - parameter range limits for ROWS / BITS
//   - mode encodings (edge-aligned vs phase-staggered)
//   - helper giving the LSB position of row k's value inside values_in
package shader_pkg;

  localparam int ROWS_MIN = 1;
  localparam int ROWS_MAX = 64;
  localparam int BITS_MIN = 1;
  localparam int BITS_MAX = 8;

  localparam logic MODE_EDGE    = 1'b0;
  localparam logic MODE_STAGGER = 1'b1;

  // Row k occupies values_in[value_lo(k,bits) +: bits].
  function automatic int unsigned value_lo(input int unsigned k, input int unsigned bits);
    return k * bits;
  endfunction

endpackage

// File: rtl/shader_row_cmp.sv
// Per-row phase adder and comparator.
// Ports:
//   value  in  BITS  committed brightness of this row
//   cnt    in  BITS  shared period counter
//   mode   in  1     MODE_EDGE: phase = cnt, MODE_STAGGER: phase = cnt + K
//   on     out 1     value > phase (combinational; registered by the top)
// K is the row index, a parameter so the offset folds into a constant add.
module shader_row_cmp
  import shader_pkg::*;
#(
  parameter int BITS = 5,
  parameter int K    = 0
) (
  input  logic [BITS-1:0] value,
  input  logic [BITS-1:0] cnt,
  input  logic            mode,
  output logic            on
);

  // Truncation to BITS gives the mod 2^BITS wrap of the row offset.
  localparam logic [BITS-1:0] K_OFF = BITS'(K);

  logic [BITS-1:0] ph;

  always_comb begin
    ph = cnt;
    if (mode == MODE_STAGGER) begin
      ph = cnt + K_OFF;
    end
    // Phase spans 0..2^BITS-1 exactly once per period, so a value v is
    // on for exactly v cycles regardless of the offset.
    on = (value > ph);
  end

endmodule

// File: rtl/shader_pwm.sv
// Parametrised PWM row shader for the POV globe LED column.
// Each row's brightness is compared against a free-running period counter;
// new values are staged on load and committed to the shadow set only at the
// period wrap so one period never mixes old and new values.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   en             advance counter / update rows (outputs hold when low)
//   mode           0 edge-aligned, 1 phase-staggered
//   load           capture values_in into the staging buffer
//   values_in      ROWS*BITS packed row values, row k at [BITS*k +: BITS]
//   pending        staged values await commit
//   rows           per-row LED on bits (registered)
//   cnt            period counter
//   period_start   pulse in first cycle of each new period
module shader_pwm
  import shader_pkg::*;
#(
  parameter int ROWS = 32,
  parameter int BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 load,
  input  logic [ROWS*BITS-1:0] values_in,
  output logic                 pending,
  output logic [ROWS-1:0]      rows,
  output logic [BITS-1:0]      cnt,
  output logic                 period_start
);

  localparam logic [BITS-1:0] CNT_MAX = {BITS{1'b1}};

  if (ROWS < ROWS_MIN || ROWS > ROWS_MAX || BITS < BITS_MIN || BITS > BITS_MAX) begin : g_param_err
    $error("shader_pwm: ROWS or BITS out of supported range");
  end

  logic [BITS-1:0] values_arr [ROWS];
  logic [BITS-1:0] staged_q   [ROWS];
  logic [BITS-1:0] staged_d   [ROWS];
  logic [BITS-1:0] shadow_q   [ROWS];
  logic [BITS-1:0] shadow_d   [ROWS];
  logic [ROWS-1:0] on_vec;
  logic [ROWS-1:0] rows_q, rows_d;
  logic [BITS-1:0] cnt_q, cnt_d;
  logic            pending_q, pending_d;
  logic            ps_q, ps_d;
  logic            wrap;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign values_arr[gi] = values_in[value_lo(gi, BITS) +: BITS];

    shader_row_cmp #(
      .BITS (BITS),
      .K    (gi)
    ) u_cmp (
      .value (shadow_q[gi]),
      .cnt   (cnt_q),
      .mode  (mode),
      .on    (on_vec[gi])
    );
  end

  always_comb begin
    wrap      = en && (cnt_q == CNT_MAX);
    cnt_d     = cnt_q;
    rows_d    = rows_q;
    ps_d      = ps_q;
    pending_d = pending_q;
    staged_d  = staged_q;
    shadow_d  = shadow_q;

    if (en) begin
      cnt_d  = cnt_q + BITS'(1);
      rows_d = on_vec;
      ps_d   = wrap;
    end

    if (load) begin
      staged_d  = values_arr;
      pending_d = 1'b1;
    end

    // A load landing on the wrap cycle goes straight to the shadow set so
    // its best-case latency is two cycles; it also leaves nothing pending.
    if (wrap) begin
      if (load) begin
        shadow_d = values_arr;
      end else if (pending_q) begin
        shadow_d = staged_q;
      end
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      rows_q    <= '0;
      ps_q      <= 1'b0;
      pending_q <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        staged_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      cnt_q     <= cnt_d;
      rows_q    <= rows_d;
      ps_q      <= ps_d;
      pending_q <= pending_d;
      staged_q  <= staged_d;
      shadow_q  <= shadow_d;
    end
  end

  assign pending      = pending_q;
  assign rows         = rows_q;
  assign cnt          = cnt_q;
  assign period_start = ps_q;

endmodule

// File: doc/shader_pwm.md
# shader_pwm

Parametrised PWM row shader for the POV globe LED column: converts one BITS-wide brightness value per row into a per-row on/off stream by comparing each value against a free-running period counter. Successor to the fixed 32-row, 5-bit shader. Adds width/depth parameters, double-buffered values committed only at period boundaries, a clock enable, and a phase-staggered mode that spreads row turn-on edges to reduce LED supply current spikes. Sits between the frame/column memory reader (which supplies `values_in`) and the LED driver shift-out logic (which consumes `rows`).

## Interface
- ROWS, default 32: number of LED rows (outputs); 1..64.
- BITS, default 5: brightness resolution; period = 2^BITS cycles; 1..8.
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; one clock, no other clock domains.
- en  in  1  advance counter and update `rows`; when low, `cnt`, `rows`, shadow and `period_start` hold.
- mode  in  1  0 = edge-aligned, 1 = phase-staggered; sampled every enabled cycle.
- load  in  1  capture `values_in` into the staging buffer this cycle.
- values_in  in  ROWS*BITS  row k value at bits [BITS*k+BITS-1 : BITS*k].
- pending  out  1  staging buffer holds values not yet committed.
- rows  out  ROWS  bit k = row k LED on.
- cnt  out  BITS  current period counter.
- period_start  out  1  one-cycle pulse, first cycle of each new period.

## Operation
- Registers: `cnt`, `staged[ROWS]`, `shadow[ROWS]`, `pending`, `rows`, `period_start`. All reset to 0. Reset is asynchronous, so it takes effect mid-period and mid-load, discarding any staged data.
- Load: a cycle with `load`=1 (independent of `en`) sets `staged`<=`values_in` and `pending`<=1. A later load before commit overwrites `staged`.
- Counter: when `en`=1, `cnt`<=`cnt`+1 mod 2^BITS.
- Commit: the wrap cycle is the cycle with `en`=1 and `cnt`=2^BITS-1. In that cycle:
  - if `load`=1, `shadow`<=`values_in` (bypass);
  - else if `pending`, `shadow`<=`staged`.
  - `pending`<=0 in either case.
- Phase per row: `ph_k` = `cnt` in mode 0, (`cnt`+k) mod 2^BITS in mode 1.
- Output: when `en`=1, `rows[k]`<=(`shadow[k]` > `ph_k`), unsigned compare.
  - value 0 never lights;
  - value v is on for exactly v of the 2^BITS cycles of a period, in both modes;
  - full-on is not reachable (max duty (2^BITS-1)/2^BITS).
- `period_start`<=1 in the cycle after a wrap cycle, 0 otherwise; the first period after reset does not pulse.
- `shadow` only changes at a wrap cycle, so a period never mixes old and new values.

## Timing
- `rows` lags `cnt` by one cycle: `rows` visible in cycle t+1 reflects `cnt` and `shadow` of cycle t.
- The first enabled edge after `rst` falls gives `rows`=0, because `shadow` is 0.
- Load-to-effect latency: `shadow` updates on the wrap edge. `rows` reflects the new values from the first cycle of the following period.
  - Worst case: 2^BITS+1 cycles from `load` to visible effect.
  - Best case: 2 cycles, when `load` occurs in the wrap cycle.
- `en`=0 during the wrap position postpones the commit until the next enabled wrap cycle.
- `mode` change takes effect on `rows` one cycle later; it is not deferred to a period boundary.
- Fully registered outputs; no combinational path from inputs to outputs.

## Structure
- The shared shader package holds:
  - the row-value slice helper (index k, BITS) for `values_in`;
  - the `MODE_EDGE`=0 and `MODE_STAGGER`=1 constants;
  - parameter-range limits.
- One sub-module, `shader_row_cmp`: per-row phase adder and comparator (`value`, `cnt`, `k`, `mode` -> on). It is instantiated ROWS times in a generate loop; top level holds counter, buffers and commit logic.

## Test plan
- Legacy pattern: ROWS=32, BITS=5, mode 0, values[k]=k, load at wrap, `en`=1. For each cycle of the following period, `rows` = ~0 << (`cnt`_prev+1) for `cnt`_prev 0..30, then all-zero at 31.
- Double buffer: shadow all 5s, then `load` all 20s at `cnt`=3. `pending`=1, and `rows` keeps 5/32 duty until the period after wrap. Then `pending`=0 and duty is 20/32; `period_start` pulses once per 32 cycles.
- Bypass and overwrite: `load` A at `cnt`=10, `load` B at `cnt`=31 (wrap). Shadow = B, never A; `pending`=0 next cycle.
- Stagger: mode 1, all rows value 16, BITS=5. Every row has 16 on cycles per period, and row k's rising edge is offset by −k cycles mod 32 from row 0's.
- Enable/reset: drop `en` for 7 cycles mid-period, and `cnt`/`rows` freeze. Then assert `rst` for one cycle at `cnt`=17 with `pending`=1. All outputs become 0 immediately (async), and the staged data is never committed.
- Corners: ROWS=1, BITS=1 with value 1 gives `rows` alternating 1,0. Value 0 gives `rows` bit never 1 across 3 periods.
